// File: rtl/hazard3_pmp_scan.sv
// Sequential PMP checker: walks the PMP table LANES entries per cycle and
// reports the lowest matching entry and the resulting access fault for one query.
module hazard3_pmp_scan #(
   parameter int unsigned PMP_REGIONS = 16,
   parameter int unsigned LANES       = 4,
   parameter int unsigned PMP_GRAIN   = 0,
   parameter int unsigned W_ADDR      = 32,
   parameter int unsigned W_DATA      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [11:0]       cfg_addr,
   input  logic              cfg_wen,
   input  logic [W_DATA-1:0] cfg_wdata,
   output logic [W_DATA-1:0] cfg_rdata,
   input  logic              mstatus_mxr,
   input  logic              q_valid,
   output logic              q_ready,
   input  logic [W_ADDR-1:0] q_addr,
   input  logic [1:0]        q_size,
   input  logic [1:0]        q_type,
   input  logic              q_m_mode,
   output logic              r_valid,
   input  logic              r_ready,
   output logic              r_kill,
   output logic              r_match,
   output logic [5:0]        r_region
);

   localparam int unsigned W_IDX       = (PMP_REGIONS > 1) ? $clog2(PMP_REGIONS) : 1;
   localparam int unsigned CFG_PER_REG = W_DATA / 8;
   localparam int unsigned G_M1        = (PMP_GRAIN >= 1) ? PMP_GRAIN - 1 : 0;
   localparam logic [W_DATA-1:0] NAPOT_MASK =
      (PMP_GRAIN >= 2) ? (W_DATA'(1) << G_M1) - W_DATA'(1) : '0;
   localparam logic [W_DATA-1:0] TOR_MASK = (W_DATA'(1) << PMP_GRAIN) - W_DATA'(1);

   localparam logic [1:0] A_OFF   = 2'd0;
   localparam logic [1:0] A_TOR   = 2'd1;
   localparam logic [1:0] A_NA4   = 2'd2;
   localparam logic [1:0] A_NAPOT = 2'd3;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [7:0]        cfg_q  [PMP_REGIONS];
   logic [W_DATA-1:0] addr_q [PMP_REGIONS];
   logic [W_DATA-1:0] eff    [PMP_REGIONS];
   logic [PMP_REGIONS:0]   tor_lock;
   logic [PMP_REGIONS-1:0] addr_lock;

   logic [1:0]        state_q, state_d;
   logic [W_IDX-1:0]  idx_q, idx_d;
   logic              q_ready_d, r_valid_d, r_kill_d, r_match_d;
   logic [5:0]        r_region_d;
   logic [W_ADDR-1:0] qa_q, ql_q;
   logic [1:0]        qt_q;
   logic              qm_q;
   logic [1:0]        q_sz;

   logic              is_cfg, is_addr;
   logic [3:0]        cfg_n;
   logic [11:0]       addr_off;
   logic [5:0]        addr_n;

   logic [W_DATA-1:0] fw, lw;
   logic [W_IDX-1:0]  lane_e  [LANES];
   logic [W_DATA-1:0] lane_lo [LANES];
   logic [LANES-1:0]  lane_f, lane_l;
   logic              found, hit_full, perm_ok, hit_kill;
   logic [W_IDX-1:0]  hit_e;

   function automatic logic [7:0] cfg_legal(input logic [7:0] w);
      logic [7:0] r;
      r      = w;
      r[6:5] = 2'b00;
      if (r[1] && !r[0]) r[1] = 1'b0;
      if (PMP_GRAIN >= 1 && r[4:3] == A_NA4) r[4:3] = A_OFF;
      return r;
   endfunction

   // Word-granular compare; TOR bounds are word addresses so byte compare reduces to this.
   function automatic logic entry_hit(input logic [1:0] a, input logic [W_DATA-1:0] w,
                                      input logic [W_DATA-1:0] pa, input logic [W_DATA-1:0] lo);
      case (a)
         A_NA4:   return w == pa;
         A_NAPOT: return ((w ^ pa) & ~(pa ^ (pa + W_DATA'(1)))) == '0;
         A_TOR:   return (w >= lo) && (w < pa);
         default: return 1'b0;
      endcase
   endfunction

   assign is_cfg   = cfg_addr[11:4] == 8'h3a;
   assign cfg_n    = cfg_addr[3:0];
   assign addr_off = cfg_addr - 12'h3b0;
   assign is_addr  = addr_off < 12'd64;
   assign addr_n   = addr_off[5:0];
   assign q_sz     = (q_size == 2'd3) ? 2'd2 : q_size;
   assign fw       = W_DATA'(qa_q >> 2);
   assign lw       = W_DATA'(ql_q >> 2);

   // Effective pmpaddr view (granularity applied) and lock qualification
   always_comb begin
      tor_lock[PMP_REGIONS] = 1'b0;
      for (int unsigned i = 0; i < PMP_REGIONS; i++) begin
         case (cfg_q[i][4:3])
            A_NAPOT: eff[i] = addr_q[i] | NAPOT_MASK;
            A_NA4:   eff[i] = addr_q[i];
            default: eff[i] = addr_q[i] & ~TOR_MASK;
         endcase
         tor_lock[i] = cfg_q[i][7] && (cfg_q[i][4:3] == A_TOR);
      end
      for (int unsigned i = 0; i < PMP_REGIONS; i++)
         addr_lock[i] = cfg_q[i][7] || tor_lock[i+1];
   end

   always_comb begin
      cfg_rdata = '0;
      for (int unsigned i = 0; i < PMP_REGIONS; i++) begin
         if (is_cfg && 32'(cfg_n) == i / CFG_PER_REG)
            cfg_rdata[(i % CFG_PER_REG)*8 +: 8] = cfg_q[i];
         if (is_addr && 32'(addr_n) == i)
            cfg_rdata = eff[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < PMP_REGIONS; i++) begin
            cfg_q[i]  <= '0;
            addr_q[i] <= '0;
         end
      end else if (cfg_wen) begin
         for (int unsigned i = 0; i < PMP_REGIONS; i++) begin
            if (is_cfg && 32'(cfg_n) == i / CFG_PER_REG && !cfg_q[i][7])
               cfg_q[i] <= cfg_legal(cfg_wdata[(i % CFG_PER_REG)*8 +: 8]);
            if (is_addr && 32'(addr_n) == i && !addr_lock[i])
               addr_q[i] <= cfg_wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         qa_q <= '0;
         ql_q <= '0;
         qt_q <= '0;
         qm_q <= 1'b0;
      end else if (state_q == S_IDLE && q_valid) begin
         qa_q <= q_addr;
         ql_q <= q_addr + (W_ADDR'(1) << q_sz) - W_ADDR'(1);
         qt_q <= q_type;
         qm_q <= q_m_mode;
      end
   end

   // Lane evaluation: lowest matching entry in the current window wins
   always_comb begin
      found    = 1'b0;
      hit_full = 1'b0;
      hit_e    = '0;
      for (int unsigned j = 0; j < LANES; j++) begin
         lane_e[j]  = idx_q + W_IDX'(j);
         lane_lo[j] = (lane_e[j] == '0) ? '0 : eff[lane_e[j] - W_IDX'(1)];
         lane_f[j]  = entry_hit(cfg_q[lane_e[j]][4:3], fw, eff[lane_e[j]], lane_lo[j]);
         lane_l[j]  = entry_hit(cfg_q[lane_e[j]][4:3], lw, eff[lane_e[j]], lane_lo[j]);
         if (!found && (lane_f[j] || lane_l[j])) begin
            found    = 1'b1;
            hit_full = lane_f[j] && lane_l[j];
            hit_e    = lane_e[j];
         end
      end
      case (qt_q)
         2'b01:   perm_ok = cfg_q[hit_e][1];
         2'b10:   perm_ok = cfg_q[hit_e][2];
         default: perm_ok = cfg_q[hit_e][0] || (cfg_q[hit_e][2] && mstatus_mxr);
      endcase
      if (!hit_full)                   hit_kill = 1'b1;
      else if (qm_q && !cfg_q[hit_e][7]) hit_kill = 1'b0;
      else                             hit_kill = !perm_ok;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         q_ready  <= 1'b1;
         r_valid  <= 1'b0;
         r_kill   <= 1'b0;
         r_match  <= 1'b0;
         r_region <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         q_ready  <= q_ready_d;
         r_valid  <= r_valid_d;
         r_kill   <= r_kill_d;
         r_match  <= r_match_d;
         r_region <= r_region_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      r_valid_d  = r_valid;
      r_kill_d   = r_kill;
      r_match_d  = r_match;
      r_region_d = r_region;
      case (state_q)
         S_IDLE: begin
            if (q_valid) begin
               state_d = S_SCAN;
               idx_d   = '0;
            end
         end
         S_SCAN: begin
            if (cfg_wen) begin
               idx_d = '0;
            end else if (found) begin
               state_d    = S_RESP;
               r_kill_d   = hit_kill;
               r_match_d  = 1'b1;
               r_region_d = 6'(hit_e);
            end else if (idx_q == W_IDX'(PMP_REGIONS - LANES)) begin
               state_d    = S_RESP;
               r_kill_d   = !qm_q;
               r_match_d  = 1'b0;
               r_region_d = '0;
            end else begin
               idx_d = idx_q + W_IDX'(LANES);
            end
         end
         S_RESP: begin
            if (r_valid && r_ready) begin
               state_d   = S_IDLE;
               r_valid_d = 1'b0;
            end else begin
               r_valid_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      q_ready_d = (state_d == S_IDLE);
   end

endmodule

// File: tb/tb_hazard3_pmp_scan.sv
// Directed bench for hazard3_pmp_scan: table of queries per PMP configuration
// plus hand sequences for lock, scan restart, response hold and mid-scan reset.
module tb_hazard3_pmp_scan;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] cfg_addr;
   logic        cfg_wen;
   logic [31:0] cfg_wdata;
   logic [31:0] cfg_rdata;
   logic        mstatus_mxr;
   logic        q_valid;
   logic        q_ready;
   logic [31:0] q_addr;
   logic [1:0]  q_size;
   logic [1:0]  q_type;
   logic        q_m_mode;
   logic        r_valid;
   logic        r_ready;
   logic        r_kill;
   logic        r_match;
   logic [5:0]  r_region;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  size;
      logic [1:0]  typ;
      logic        m;
      logic        mxr;
      logic        kill;
      logic        match;
      logic [5:0]  region;
      int          lat;
   } vec_t;

   vec_t tab [30];

   always #5 clk = ~clk;

   hazard3_pmp_scan dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_addr    (cfg_addr),
      .cfg_wen     (cfg_wen),
      .cfg_wdata   (cfg_wdata),
      .cfg_rdata   (cfg_rdata),
      .mstatus_mxr (mstatus_mxr),
      .q_valid     (q_valid),
      .q_ready     (q_ready),
      .q_addr      (q_addr),
      .q_size      (q_size),
      .q_type      (q_type),
      .q_m_mode    (q_m_mode),
      .r_valid     (r_valid),
      .r_ready     (r_ready),
      .r_kill      (r_kill),
      .r_match     (r_match),
      .r_region    (r_region)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
      cfg_addr  = a;
      cfg_wdata = d;
      cfg_wen   = 1'b1;
      tick();
      cfg_wen   = 1'b0;
   endtask

   task automatic csr_chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
      cfg_addr = a;
      #1;
      chk(nm, cfg_rdata, exp);
   endtask

   task automatic wait_ready();
      int w = 0;
      while (!q_ready && w < 20) begin
         tick();
         w++;
      end
      if (!q_ready) begin
         checks++;
         errors++;
         $display("FAIL q_ready_timeout: got 0 expected 1");
      end
   endtask

   task automatic accept(input logic [31:0] a, input logic [1:0] s, input logic [1:0] t,
                         input logic m, input logic mxr);
      wait_ready();
      q_addr      = a;
      q_size      = s;
      q_type      = t;
      q_m_mode    = m;
      mstatus_mxr = mxr;
      q_valid     = 1'b1;
      tick();
      q_valid     = 1'b0;
   endtask

   task automatic wait_resp(inout int lat);
      while (!r_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic run_vec(input int i);
      int lat = 0;
      accept(tab[i].addr, tab[i].size, tab[i].typ, tab[i].m, tab[i].mxr);
      wait_resp(lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(tab[i].lat));
      chk($sformatf("v%0d_kill", i), 32'(r_kill), 32'(tab[i].kill));
      chk($sformatf("v%0d_match", i), 32'(r_match), 32'(tab[i].match));
      chk($sformatf("v%0d_region", i), 32'(r_region), 32'(tab[i].region));
      r_ready = 1'b1;
      tick();
      r_ready = 1'b0;
   endtask

   initial begin
      int lat;
      //        addr          sz    typ   m     mxr   kill  match region lat
      // Phase 1: e0 NAPOT 0..0xfff R, e2 NA4 0x2000 RWX, e3 NA4 0x3000 X
      tab[0]  = '{32'h0000_0800, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 2};
      tab[1]  = '{32'h0000_0800, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 2};
      tab[2]  = '{32'h0000_0ffc, 2'd2, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 2};
      tab[3]  = '{32'h0000_0800, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 2};
      tab[4]  = '{32'h0000_2002, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd2, 2};
      tab[5]  = '{32'h0000_2002, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 6'd2, 2};
      tab[6]  = '{32'h0000_2000, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 2};
      tab[7]  = '{32'h0000_0ffe, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 2};
      tab[8]  = '{32'h0000_3000, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd3, 2};
      tab[9]  = '{32'h0000_3000, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd3, 2};
      tab[10] = '{32'h0000_3000, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 6'd3, 2};
      tab[11] = '{32'h0000_4000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 5};
      tab[12] = '{32'h0000_4000, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 5};
      tab[13] = '{32'h0000_2000, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 2};
      tab[14] = '{32'h0000_0800, 2'd2, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 2};
      tab[15] = '{32'h0000_2003, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 2};
      tab[16] = '{32'h0000_0fff, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 2};
      // Phase 2: e0 OFF 0x400, e5 TOR [pmpaddr4=0, 0x800) X
      tab[17] = '{32'h0000_1000, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 3};
      tab[18] = '{32'h0000_1ffc, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 3};
      tab[19] = '{32'h0000_1ffe, 2'd2, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 6'd5, 3};
      tab[20] = '{32'h0000_2000, 2'd2, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 5};
      tab[21] = '{32'h0000_0000, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd5, 3};
      tab[22] = '{32'h0000_0000, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 6'd5, 3};
      tab[23] = '{32'h0000_1000, 2'd2, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 5};
      // Phase 3: e1 TOR L=1 X only, [0x400, 0x1000)
      tab[24] = '{32'h0000_0800, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 6'd1, 2};
      tab[25] = '{32'h0000_0800, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 6'd1, 2};
      tab[26] = '{32'h0000_0200, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 5};
      tab[27] = '{32'h0000_03fe, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd1, 2};
      // Phase 4: empty table
      tab[28] = '{32'h0000_0100, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 5};
      tab[29] = '{32'hffff_fffc, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 5};

      rst_n = 1'b0; cfg_addr = '0; cfg_wen = 1'b0; cfg_wdata = '0; mstatus_mxr = 1'b0;
      q_valid = 1'b0; q_addr = '0; q_size = '0; q_type = '0; q_m_mode = 1'b0; r_ready = 1'b0;
      do_reset();
      chk("rst_q_ready", 32'(q_ready), 32'd1);
      chk("rst_r_valid", 32'(r_valid), 32'd0);
      chk("rst_r_kill", 32'(r_kill), 32'd0);
      chk("rst_r_match", 32'(r_match), 32'd0);
      chk("rst_r_region", 32'(r_region), 32'd0);
      csr_chk("rst_pmpcfg0", 12'h3a0, 32'h0);
      csr_chk("rst_pmpaddr0", 12'h3b0, 32'h0);

      csr_wr(12'h3b0, 32'h0000_01ff);
      csr_wr(12'h3b2, 32'h0000_0800);
      csr_wr(12'h3b3, 32'h0000_0c00);
      csr_wr(12'h3a0, 32'h1417_0019);
      csr_chk("p1_pmpcfg0", 12'h3a0, 32'h1417_0019);
      csr_chk("p1_pmpaddr2", 12'h3b2, 32'h0000_0800);
      for (int i = 0; i <= 16; i++) run_vec(i);

      do_reset();
      csr_wr(12'h3b0, 32'h0000_0400);
      csr_wr(12'h3b5, 32'h0000_0800);
      csr_wr(12'h3a1, 32'h0000_0c00);
      for (int i = 17; i <= 22; i++) run_vec(i);
      csr_wr(12'h3b4, 32'h0000_0800);
      run_vec(23);
      csr_wr(12'h3b4, 32'h0000_0000);

      // Config write in the second scan cycle restarts the walk against the new table
      lat = 0;
      accept(32'h0000_1000, 2'd2, 2'd2, 1'b0, 1'b0);
      tick();
      lat++;
      chk("restart_q_ready_busy", 32'(q_ready), 32'd0);
      csr_wr(12'h3a1, 32'h0000_0900);
      lat++;
      wait_resp(lat);
      chk("restart_latency", 32'(lat), 32'd5);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("hold%0d_r_valid", i), 32'(r_valid), 32'd1);
         chk($sformatf("hold%0d_q_ready", i), 32'(q_ready), 32'd0);
      end
      chk("restart_kill", 32'(r_kill), 32'd1);
      chk("restart_match", 32'(r_match), 32'd1);
      chk("restart_region", 32'(r_region), 32'd5);
      r_ready = 1'b1;
      tick();
      r_ready = 1'b0;
      chk("restart_done_r_valid", 32'(r_valid), 32'd0);
      chk("restart_done_q_ready", 32'(q_ready), 32'd1);
      csr_chk("restart_pmpcfg1", 12'h3a1, 32'h0000_0900);

      do_reset();
      csr_wr(12'h3b0, 32'h0000_0100);
      csr_wr(12'h3b1, 32'h0000_0400);
      csr_wr(12'h3a0, 32'h0000_8c00);
      csr_wr(12'h3b0, 32'h0000_0055);
      csr_wr(12'h3b1, 32'h0000_0055);
      csr_wr(12'h3a0, 32'h0000_0066);
      csr_chk("lock_pmpcfg0", 12'h3a0, 32'h0000_8c04);
      csr_chk("lock_pmpaddr0", 12'h3b0, 32'h0000_0100);
      csr_chk("lock_pmpaddr1", 12'h3b1, 32'h0000_0400);
      for (int i = 24; i <= 27; i++) run_vec(i);

      // Reset on the edge that would end the scan discards the query and clears locks
      accept(32'h0000_0800, 2'd2, 2'd0, 1'b1, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("scanrst_r_valid", 32'(r_valid), 32'd0);
      chk("scanrst_q_ready", 32'(q_ready), 32'd1);
      tick();
      tick();
      chk("scanrst_r_valid_later", 32'(r_valid), 32'd0);
      csr_chk("scanrst_pmpcfg0", 12'h3a0, 32'h0);

      for (int i = 28; i <= 29; i++) run_vec(i);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
